// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the fetch handshake, decoder controls and status
// outputs of the instruction sequencer.
//   master : the sequencer (drives fetch request, phase, pc, status)
//   slave  : the surroundings (imem, decoder, data-memory stall, control)
interface pc_sequencer_if #(
    parameter int PC_W = 64
);
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic            instr_latch;
    logic [2:0]      phase;
    logic            stall;
    logic            branch;
    logic [2:0]      branch_sel;
    logic            jal_sel;
    logic            jalr_sel;
    logic [PC_W-1:0] offset;
    logic            halt_req;
    logic [PC_W-1:0] pc;
    logic            retire;
    logic [31:0]     retired_count;
    logic            halted;
    logic            fault;

    modport master (
        input  start, imem_ack, stall, branch, branch_sel, jal_sel, jalr_sel,
               offset, halt_req,
        output imem_req, imem_addr, instr_latch, phase, pc, retire,
               retired_count, halted, fault
    );

    modport slave (
        output start, imem_ack, stall, branch, branch_sel, jal_sel, jalr_sel,
               offset, halt_req,
        input  imem_req, imem_addr, instr_latch, phase, pc, retire,
               retired_count, halted, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer. Owns the program counter,
// steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes the
// instruction fetch, holds MEM on data-memory stalls, computes next-PC from
// the decoder's branch/jump controls, and reports retire/halt/fault.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : pc_sequencer_if.master (fetch handshake, decoder controls,
//                pc, phase, retire, retired_count, halted, fault)
module pc_sequencer #(
    parameter int              PC_W       = 64,
    parameter int unsigned     IMEM_DEPTH = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.master   bus
);

    // Pipeline phases share their encoding with the phase output so that the
    // output decode is a simple range check.
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_IDLE   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);
    localparam logic [PC_W-1:0] ONE   = PC_W'(1);

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [PC_W-1:0] next_pc;

    // Next-PC selection. Branch selects 4..6 are not a branch match and fall
    // through to the jal/jalr/default rules.
    always_comb begin
        next_pc = pc_q + ONE;
        if (bus.branch && (bus.branch_sel <= 3'd3)) begin
            next_pc = pc_q + bus.offset;
        end else if (bus.branch && (bus.branch_sel == 3'd7)) begin
            next_pc = pc_q + ONE;
        end else if (bus.jal_sel) begin
            next_pc = pc_q + bus.offset;
        end else if (bus.jalr_sel) begin
            next_pc = bus.offset;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  if (bus.imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_MEM;
            S_MEM:    if (!bus.stall) state_d = S_WB;
            S_WB: begin
                // pc loads even on a fault so the offending target is visible.
                pc_d  = next_pc;
                cnt_d = cnt_q + 32'd1;
                if (next_pc >= DEPTH) begin
                    state_d = S_FAULT;
                end else if (bus.halt_req) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:   if (bus.start) state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req      = (state_q == S_FETCH);
    assign bus.imem_addr     = pc_q;
    // The only combinational input-to-output path.
    assign bus.instr_latch   = (state_q == S_FETCH) && bus.imem_ack;
    assign bus.phase         = (state_q <= S_WB) ? state_q : 3'd7;
    assign bus.pc            = pc_q;
    assign bus.retire        = (state_q == S_WB);
    assign bus.retired_count = cnt_q;
    assign bus.halted        = (state_q == S_HALT);
    assign bus.fault         = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario tasks plus a randomized run checked against an
// instruction-level reference model (next-PC rules, retire count, halt/fault).
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [63:0] exp_cnt;

    pc_sequencer_if #(.PC_W(64)) bus ();

    pc_sequencer #(.PC_W(64), .IMEM_DEPTH(32), .RESET_PC(64'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          latches;
        int          bad;
        int          mem_cycles;
        int          retires;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.stall      = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_sel = 3'd0;
        bus.jal_sel    = 1'b0;
        bus.jalr_sel   = 1'b0;
        bus.offset     = '0;
        bus.halt_req   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Reference next-PC, straight from the priority list of rules.
    function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic br,
        input logic [2:0] sel, input logic jal, input logic jalr, input logic [63:0] off);
        if (br && sel < 3'd4) return pc + off;
        if (br && sel == 3'd7) return pc + 64'd1;
        if (jal) return pc + off;
        if (jalr) return off;
        return pc + 64'd1;
    endfunction

    // Drives one instruction from its first FETCH cycle through WB and records
    // what was observed; the caller judges the observations.
    task automatic run_instr(input int ack_wait, input int stall_n, input logic br,
        input logic [2:0] sel, input logic jal, input logic jalr, input logic [63:0] off,
        input logic hreq, output obs_t o);
        o.addr = '0; o.latches = 0; o.bad = 0; o.mem_cycles = 0; o.retires = 0;
        for (int k = 0; k < ack_wait; k++) begin
            bus.imem_ack = 1'b0;
            #1;
            if (bus.phase !== 3'd0 || bus.imem_req !== 1'b1) o.bad++;
            if (bus.instr_latch === 1'b1) o.latches++;
            if (bus.retire === 1'b1) o.retires++;
            tick();
        end
        bus.imem_ack = 1'b1;
        #1;
        o.addr = bus.imem_addr;
        if (bus.phase !== 3'd0 || bus.imem_req !== 1'b1) o.bad++;
        if (bus.instr_latch === 1'b1) o.latches++;
        if (bus.retire === 1'b1) o.retires++;
        tick();
        bus.imem_ack = 1'b0;
        for (int p = 1; p <= 2; p++) begin
            #1;
            if (bus.phase !== 3'(p) || bus.imem_req !== 1'b0) o.bad++;
            if (bus.instr_latch === 1'b1) o.latches++;
            if (bus.retire === 1'b1) o.retires++;
            tick();
        end
        for (int k = 0; k <= stall_n; k++) begin
            bus.stall = (k < stall_n);
            #1;
            if (bus.phase === 3'd3) o.mem_cycles++;
            else o.bad++;
            if (bus.retire === 1'b1) o.retires++;
            tick();
        end
        bus.stall      = 1'b0;
        bus.branch     = br;
        bus.branch_sel = sel;
        bus.jal_sel    = jal;
        bus.jalr_sel   = jalr;
        bus.offset     = off;
        bus.halt_req   = hreq;
        #1;
        if (bus.phase !== 3'd4) o.bad++;
        if (bus.retire === 1'b1) o.retires++;
        tick();
        clear_inputs();
        exp_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.phase !== 3'd7) begin n_bad++; $display("FAIL reset_phase: got %0d want 7", bus.phase); end
        n_cmp++; if (bus.pc !== 64'd0) begin n_bad++; $display("FAIL reset_pc: got %0h want 0", bus.pc); end
        n_cmp++; if (bus.retired_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.retired_count); end
        n_cmp++; if ({bus.imem_req, bus.instr_latch, bus.retire, bus.halted, bus.fault} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000", {bus.imem_req, bus.instr_latch, bus.retire, bus.halted, bus.fault}); end
    endtask

    task automatic test_sequential();
        bus.imem_ack = 1'b1;
        pulse_start();
        for (int c = 0; c < 15; c++) begin
            #1;
            n_cmp++; if (bus.phase !== 3'(c % 5)) begin n_bad++; $display("FAIL seq_phase c=%0d: got %0d want %0d", c, bus.phase, c % 5); end
            n_cmp++; if (bus.retire !== (c % 5 == 4)) begin n_bad++; $display("FAIL seq_retire c=%0d: got %b want %b", c, bus.retire, (c % 5 == 4)); end
            if (c % 5 == 0) begin
                n_cmp++; if (bus.imem_addr !== 64'(c / 5)) begin n_bad++; $display("FAIL seq_addr c=%0d: got %0h want %0h", c, bus.imem_addr, c / 5); end
            end
            tick();
        end
        bus.imem_ack = 1'b0;
        exp_cnt = 3;
        n_cmp++; if (bus.retired_count !== 32'd3) begin n_bad++; $display("FAIL seq_count: got %0d want 3", bus.retired_count); end
        n_cmp++; if (bus.pc !== 64'd3) begin n_bad++; $display("FAIL seq_pc: got %0h want 3", bus.pc); end
    endtask

    task automatic test_branches();
        obs_t o;
        run_instr(0, 0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 1'b0, o);
        n_cmp++; if (bus.pc !== 64'd4) begin n_bad++; $display("FAIL br_default: got %0h want 4", bus.pc); end
        run_instr(0, 0, 1'b1, 3'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, o);
        n_cmp++; if (o.addr !== 64'd4) begin n_bad++; $display("FAIL br_fetch: got %0h want 4", o.addr); end
        n_cmp++; if (bus.pc !== 64'd1) begin n_bad++; $display("FAIL br_bne_neg: got %0h want 1", bus.pc); end
        run_instr(0, 0, 1'b0, 3'd0, 1'b1, 1'b0, 64'd5, 1'b0, o);
        n_cmp++; if (bus.pc !== 64'd6) begin n_bad++; $display("FAIL br_jal: got %0h want 6", bus.pc); end
        run_instr(0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd2, 1'b0, o);
        n_cmp++; if (bus.pc !== 64'd2) begin n_bad++; $display("FAIL br_jalr: got %0h want 2", bus.pc); end
        n_cmp++; if (bus.retired_count !== exp_cnt[31:0]) begin n_bad++; $display("FAIL br_count: got %0d want %0d", bus.retired_count, exp_cnt); end
    endtask

    task automatic test_wait_stall();
        obs_t o;
        run_instr(7, 4, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 1'b0, o);
        n_cmp++; if (o.bad !== 0) begin n_bad++; $display("FAIL ws_phase_req: got %0d bad cycles want 0", o.bad); end
        n_cmp++; if (o.latches !== 1) begin n_bad++; $display("FAIL ws_latch: got %0d pulses want 1", o.latches); end
        n_cmp++; if (o.mem_cycles !== 5) begin n_bad++; $display("FAIL ws_mem_hold: got %0d want 5", o.mem_cycles); end
        n_cmp++; if (o.retires !== 1) begin n_bad++; $display("FAIL ws_retire: got %0d want 1", o.retires); end
        n_cmp++; if (bus.pc !== 64'd3) begin n_bad++; $display("FAIL ws_pc: got %0h want 3", bus.pc); end
    endtask

    task automatic test_halt();
        obs_t o;
        run_instr(0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd9, 1'b0, o);
        run_instr(1, 0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 1'b1, o);
        n_cmp++; if (o.addr !== 64'd9) begin n_bad++; $display("FAIL halt_fetch: got %0h want 9", o.addr); end
        for (int k = 0; k < 3; k++) begin
            bus.start = 1'b0;
            n_cmp++; if ({bus.halted, bus.phase, bus.imem_req} !== {1'b1, 3'd7, 1'b0}) begin
                n_bad++; $display("FAIL halt_state k=%0d: got h=%b ph=%0d req=%b want h=1 ph=7 req=0", k, bus.halted, bus.phase, bus.imem_req); end
            tick();
        end
        n_cmp++; if (bus.pc !== 64'd10) begin n_bad++; $display("FAIL halt_pc: got %0h want 10", bus.pc); end
        pulse_start();
        n_cmp++; if ({bus.halted, bus.phase, bus.imem_req} !== {1'b0, 3'd0, 1'b1}) begin
            n_bad++; $display("FAIL halt_resume: got h=%b ph=%0d req=%b want h=0 ph=0 req=1", bus.halted, bus.phase, bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 64'd10) begin n_bad++; $display("FAIL halt_addr: got %0h want 10", bus.imem_addr); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [63:0] mpc, t, off, nxt;
        logic br, jal, jalr, hreq;
        logic [2:0] sel;
        int aw, sn, kind;
        mpc = bus.pc;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            t    = 64'($urandom_range(0, 31));
            br = 1'b0; sel = 3'd0; jal = 1'b0; jalr = 1'b0; off = 64'($urandom);
            case (kind)
                1: begin br = 1'b1; sel = 3'($urandom_range(0, 3)); off = t - mpc; end
                2: begin br = 1'b1; sel = 3'd7; end
                3: begin jal = 1'b1; off = t - mpc; end
                4: begin jalr = 1'b1; off = t; end
                5: begin br = 1'b1; sel = 3'($urandom_range(4, 6)); jal = 1'($urandom);
                         jalr = 1'($urandom); off = jal ? t - mpc : t; end
                default: ;
            endcase
            nxt = ref_next(mpc, br, sel, jal, jalr, off);
            if (nxt >= 64'd32) begin
                br = 1'b0; jal = 1'b0; jalr = 1'b1; off = t; nxt = t;
            end
            hreq = ($urandom_range(0, 7) == 0);
            aw   = $urandom_range(0, 3);
            sn   = $urandom_range(0, 3);
            run_instr(aw, sn, br, sel, jal, jalr, off, hreq, o);
            n_cmp++; if (o.addr !== mpc) begin n_bad++; $display("FAIL rnd_fetch i=%0d: got %0h want %0h", i, o.addr, mpc); end
            n_cmp++; if (o.bad !== 0 || o.retires !== 1 || o.latches !== 1 || o.mem_cycles !== sn + 1) begin
                n_bad++; $display("FAIL rnd_timing i=%0d: got bad=%0d ret=%0d lat=%0d mem=%0d want 0/1/1/%0d", i, o.bad, o.retires, o.latches, o.mem_cycles, sn + 1); end
            n_cmp++; if (bus.pc !== nxt) begin n_bad++; $display("FAIL rnd_pc i=%0d: got %0h want %0h", i, bus.pc, nxt); end
            n_cmp++; if (bus.retired_count !== exp_cnt[31:0]) begin n_bad++; $display("FAIL rnd_count i=%0d: got %0d want %0d", i, bus.retired_count, exp_cnt); end
            n_cmp++; if (bus.halted !== hreq || bus.fault !== 1'b0) begin
                n_bad++; $display("FAIL rnd_status i=%0d: got h=%b f=%b want h=%b f=0", i, bus.halted, bus.fault, hreq); end
            if (hreq) pulse_start();
            mpc = nxt;
        end
    endtask

    task automatic test_fault();
        obs_t o;
        for (int h = 0; h < 2; h++) begin
            do_reset();
            pulse_start();
            run_instr(0, 0, 1'b0, 3'd0, 1'b0, 1'b1, 64'd31, 1'b0, o);
            run_instr(0, 1, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 1'(h), o);
            n_cmp++; if (o.retires !== 1) begin n_bad++; $display("FAIL fault_retire h=%0d: got %0d want 1", h, o.retires); end
            n_cmp++; if (bus.pc !== 64'd32) begin n_bad++; $display("FAIL fault_pc h=%0d: got %0h want 32", h, bus.pc); end
            pulse_start();
            tick();
            n_cmp++; if ({bus.fault, bus.halted, bus.phase, bus.imem_req} !== {1'b1, 1'b0, 3'd7, 1'b0}) begin
                n_bad++; $display("FAIL fault_state h=%0d: got f=%b h=%b ph=%0d req=%b want f=1 h=0 ph=7 req=0", h, bus.fault, bus.halted, bus.phase, bus.imem_req); end
            n_cmp++; if (bus.retired_count !== 32'd2) begin n_bad++; $display("FAIL fault_count h=%0d: got %0d want 2", h, bus.retired_count); end
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        do_reset();
        pulse_start();
        run_instr(0, 0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 1'b0, o);
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        tick();
        bus.stall = 1'b1;
        tick();
        n_cmp++; if (bus.phase !== 3'd3 || bus.retired_count !== 32'd1) begin
            n_bad++; $display("FAIL ar_pre: got ph=%0d cnt=%0d want ph=3 cnt=1", bus.phase, bus.retired_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.phase, bus.imem_req, bus.retire, bus.halted, bus.fault} !== {3'd7, 4'b0}) begin
            n_bad++; $display("FAIL ar_flags: got ph=%0d req=%b ret=%b h=%b f=%b want 7/0/0/0/0", bus.phase, bus.imem_req, bus.retire, bus.halted, bus.fault); end
        n_cmp++; if (bus.pc !== 64'd0 || bus.retired_count !== 32'd0) begin
            n_bad++; $display("FAIL ar_pc_count: got pc=%0h cnt=%0d want 0/0", bus.pc, bus.retired_count); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        pulse_start();
        n_cmp++; if (bus.phase !== 3'd0 || bus.imem_addr !== 64'd0 || bus.retired_count !== 32'd0) begin
            n_bad++; $display("FAIL ar_restart: got ph=%0d addr=%0h cnt=%0d want 0/0/0", bus.phase, bus.imem_addr, bus.retired_count); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_cnt = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branches();
        test_wait_stall();
        test_halt();
        test_random();
        test_fault();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
